// File: rtl/booth_r8_seq.sv
// Control sequencer for a radix-8 Booth multiplier datapath: walks the multiplier three bits
// per step and emits the Load/Add/Addc/Shift command stream with the multiple magnitude.
module booth_r8_seq #(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = (N + 2) / 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_qbits,
  output logic [2:0] o_si,
  output logic [2:0] o_mag,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);

  localparam logic [2:0] SiIdle  = 3'b000;
  localparam logic [2:0] SiAdd   = 3'b001;
  localparam logic [2:0] SiAddc  = 3'b010;
  localparam logic [2:0] SiLoad  = 3'b011;
  localparam logic [2:0] SiShift = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDecode,
    StOp,
    StShift,
    StDone
  } state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic            r_neg, w_neg_next;
  logic [2:0]      r_mag, w_mag_next;

  logic [2:0]      w_sum;
  logic [2:0]      w_dmag;
  logic            w_dneg;

  // d = w_sum - 4*q[3] where w_sum = 2*q[2] + q[1] + q[0] lies in 0..4.
  assign w_sum     = {1'b0, i_qbits[2], 1'b0} + {2'b00, i_qbits[1]} + {2'b00, i_qbits[0]};
  assign w_dmag    = i_qbits[3] ? (3'd4 - w_sum) : w_sum;
  assign w_dneg    = i_qbits[3] && (w_sum != 3'd4);
  assign w_cnt_inc = r_cnt + CntW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_mag   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_neg   <= w_neg_next;
      r_mag   <= w_mag_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_neg_next   = r_neg;
    w_mag_next   = r_mag;
    unique case (r_state)
      StIdle:   if (i_start) w_state_next = StLoad;
      StLoad: begin
        w_cnt_next   = '0;
        w_state_next = StDecode;
      end
      StDecode: begin
        w_neg_next   = w_dneg;
        w_mag_next   = w_dmag;
        w_state_next = (w_dmag == 3'd0) ? StShift : StOp;
      end
      StOp:     w_state_next = StShift;
      StShift: begin
        w_cnt_next   = w_cnt_inc;
        w_state_next = (w_cnt_inc == CntW'(DIGITS)) ? StDone : StDecode;
      end
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_si   = SiIdle;
    o_mag  = 3'd0;
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StIdle:   ;
      StLoad: begin
        o_si   = SiLoad;
        o_busy = 1'b1;
      end
      StDecode: o_busy = 1'b1;
      StOp: begin
        o_si   = r_neg ? SiAddc : SiAdd;
        o_mag  = r_mag;
        o_busy = 1'b1;
      end
      StShift: begin
        o_si   = SiShift;
        o_busy = 1'b1;
      end
      StDone:   o_done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_booth_r8_seq.sv
// Directed bench for booth_r8_seq: a model fills a per-cycle expectation queue for each
// multiply, and every cycle the head of the queue is popped and checked against the outputs.
module tb_booth_r8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] qbits;
  logic [2:0] si;
  logic [2:0] mag;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] si;
    logic [2:0] mag;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] qb_q[$];

  booth_r8_seq #(.N(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .i_qbits (qbits),
    .o_si    (si),
    .o_mag   (mag),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] s, input logic [2:0] m, input logic b,
                              input logic d);
    exp_t e;
    e.si = s; e.mag = m; e.busy = b; e.done = d;
    return e;
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t o;
    o = mk(si, mag, busy, done);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed si=%b mag=%0d busy=%b done=%b expected si=%b mag=%0d busy=%b done=%b",
             tag, o.si, o.mag, o.busy, o.done, e.si, e.mag, e.busy, e.done);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected command stream for one multiply and the window to present each cycle.
  task automatic push_op(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
    logic [3:0] w;
    int d;
    exp_q.push_back(mk(3'b011, 3'd0, 1'b1, 1'b0));
    qb_q.push_back(4'b0000);
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      d = -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
      exp_q.push_back(mk(3'b000, 3'd0, 1'b1, 1'b0));
      qb_q.push_back(w);
      if (d > 0) exp_q.push_back(mk(3'b001, 3'(d), 1'b1, 1'b0));
      if (d < 0) exp_q.push_back(mk(3'b010, 3'(-d), 1'b1, 1'b0));
      if (d != 0) qb_q.push_back(4'b0000);
      exp_q.push_back(mk(3'b100, 3'd0, 1'b1, 1'b0));
      qb_q.push_back(4'b0000);
    end
    exp_q.push_back(mk(3'b000, 3'd0, 1'b0, 1'b1));
    qb_q.push_back(4'b0000);
  endtask

  // Runs one multiply; on return the bench sits #1 into the Idle cycle after Done.
  task automatic run(input string tag, input logic [3:0] w0, input logic [3:0] w1,
                     input logic [3:0] w2, input int exp_busy, input bit noise, input bit hold,
                     input bit started);
    exp_t e;
    int nbusy = 0;
    int model_busy = 0;
    int cyc = 0;
    push_op(w0, w1, w2);
    foreach (exp_q[i]) if (exp_q[i].busy) model_busy++;
    if (!started) begin
      start = 1'b1;
      step();
    end
    while (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      qbits = qb_q.pop_front();
      start = noise ? (e.done || cyc[0]) : hold;
      check($sformatf("%s_c%0d", tag, cyc), e);
      if (busy) nbusy++;
      cyc++;
      step();
    end
    start = hold;
    check_int({tag, "_busy"}, nbusy, model_busy);
    if (exp_busy >= 0) check_int({tag, "_busy_ref"}, nbusy, exp_busy);
    check({tag, "_idle"}, mk(3'b000, 3'd0, 1'b0, 1'b0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    qbits = 4'b0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_%0d", i), mk(3'b000, 3'd0, 1'b0, 1'b0));
    end
    rst = 1'b0;

    // Start still high as reset falls: LOAD on the next cycle.
    run("m20", 4'b1000, 4'b0101, 4'b0000, 9, 1'b0, 1'b0, 1'b0);
    run("mneg1", 4'b1110, 4'b1111, 4'b1111, 8, 1'b0, 1'b0, 1'b0);
    run("ext_a", 4'b0111, 4'b1000, 4'b0011, 10, 1'b0, 1'b0, 1'b0);
    run("ext_b", 4'b1100, 4'b0001, 4'b1011, 10, 1'b0, 1'b0, 1'b0);

    // Start pulses during Busy and Done must not disturb or restart the sequence.
    run("noise", 4'b0110, 4'b0000, 4'b1001, -1, 1'b1, 1'b0, 1'b0);
    step();
    check("noise_stay_idle", mk(3'b000, 3'd0, 1'b0, 1'b0));

    // Start held high: new LOAD two cycles after Done.
    run("hold1", 4'b0101, 4'b1010, 4'b1111, -1, 1'b0, 1'b1, 1'b0);
    step();
    run("hold2", 4'b0010, 4'b0100, 4'b0000, -1, 1'b0, 1'b0, 1'b1);

    // Reset during OP of digit 2.
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_load", mk(3'b011, 3'd0, 1'b1, 1'b0));
    qbits = 4'b0011;
    step();
    check("abort_dec1", mk(3'b000, 3'd0, 1'b1, 1'b0));
    step();
    check("abort_op1", mk(3'b001, 3'd2, 1'b1, 1'b0));
    step();
    check("abort_sh1", mk(3'b100, 3'd0, 1'b1, 1'b0));
    qbits = 4'b1101;
    step();
    check("abort_dec2", mk(3'b000, 3'd0, 1'b1, 1'b0));
    step();
    check("abort_op2", mk(3'b010, 3'd1, 1'b1, 1'b0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rst", mk(3'b000, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("abort_quiet_%0d", i), mk(3'b000, 3'd0, 1'b0, 1'b0));
    end
    run("after_abort", 4'b1000, 4'b0101, 4'b0000, 9, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_r8_seq.md
Name: booth_r8_seq

Overview:
- Control sequencer for the radix-8 Booth multiplier datapath.
- Accepts a Start request and scans the multiplier three bits per step using a 4-bit Booth window returned by the datapath.
- Issues the Load/Add/Addc/Shift command stream on Si, plus the multiple magnitude for each add.
- Replaces bench-driven Si stimulus; signals completion with a one-cycle Done pulse.

Parameters:
- N, 8, operand width in bits.
- DIGITS, (N+2)/3, number of radix-8 Booth digits; 3 for N=8.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- Qbits  input  4  Booth window {q[i+2],q[i+1],q[i],q[i-1]} from the datapath multiplier register; q[-1]=0 after Load.
- Si     output 3  datapath command: 000 Idle, 001 Add, 010 Addc (add two's complement), 011 Load, 100 Shift.
- Mag    output 3  multiple select 0..4 (|digit|); valid when Si is Add or Addc, 0 otherwise.
- Busy   output 1  high from LOAD through the last SHIFT.
- Done   output 1  one-cycle pulse after the final SHIFT.

Behaviour:
- Reset has priority over all other inputs.
  - Next state is IDLE; Si=000, Mag=0, Busy=0, Done=0; digit counter=0; stored digit=0.
  - Reset mid-operation aborts immediately, with no further commands.
- All outputs are Moore outputs of registered state and a registered digit. There is no combinational path from Qbits or Start to any output.
- States and transitions:
  - IDLE: Si=000. If Start=1 at the edge, go to LOAD; otherwise stay.
  - LOAD: Si=011, Busy=1. Clear the counter. Go to DECODE.
  - DECODE: Si=000, Busy=1.
    - Register digit d = -4*Qbits[3] + 2*Qbits[2] + Qbits[1] + Qbits[0], range -4..+4.
    - If d=0, go to SHIFT (OP is skipped); otherwise go to OP.
  - OP: Busy=1, Mag=|d|. Si=001 if d>0, Si=010 if d<0. Go to SHIFT.
  - SHIFT: Si=100, Busy=1. Increment the counter.
    - If the counter reaches DIGITS, go to DONE; otherwise go to DECODE.
  - DONE: Si=000, Busy=0, Done=1 for exactly one cycle. Go to IDLE.
- Per-digit cost: 3 cycles (DECODE, OP, SHIFT), or 2 cycles when d=0.
- Total Busy cycles: 1 + sum of per-digit costs, i.e. 7..10 for N=8.
  - Start sampled at edge k gives LOAD in cycle k+1; Done follows the last Busy cycle.
- Qbits must be stable during DECODE. The datapath updates it only on Load/Shift, so the controller samples it one cycle after those commands.
- Start is ignored while Busy=1 and in DONE. A back-to-back request is accepted at the first IDLE edge, giving a minimum gap of one Idle cycle between operations.
- Window boundary cases:
  - 0000 and 1111 give d=0: no add, shift only.
  - 1000 gives d=-4: Addc, Mag=4.
  - 0111 gives d=+4: Add, Mag=4.
  - Mag never exceeds 4.
- Counter width is clog2(DIGITS+1). The counter never wraps, because it clears in LOAD.
- Si never carries 101..111.

Test Plan:
- Reset: hold Reset with Start=1 for 3 cycles → Si=000, Mag=0, Busy=0, Done=0 throughout; first LOAD appears one cycle after Reset falls.
- Multiplier 20 (00010100), bench drives Qbits 1000, 0101, 0000 per DECODE → Si sequence 011,000,010(Mag4),100,000,001(Mag3),100,000,100,000(Done=1); Busy high for 9 cycles.
- Multiplier -1 (Qbits 1110, 1111, 1111) → digits -1,0,0 → 011,000,010(Mag1),100,000,100,000,100 then Done; 8 Busy cycles.
- Digit extremes: Qbits 0111 → Add with Mag=4; Qbits 1000 → Addc with Mag=4; Qbits 0011 → Add with Mag=2; Qbits 1100 → Addc with Mag=2.
- Start pulses during Busy and during DONE → ignored, with no restart and no change to the sequence; Start held high → new LOAD exactly 2 cycles after Done.
- Reset asserted in the OP cycle of digit 2 → next cycle Si=000, Busy=0, no Done pulse; a subsequent Start runs the full sequence from LOAD.
